// File: rtl/stream_pattern_tester.sv
// Pattern generator (TX) and locking checker (RX) for 245-FIFO stream ports.
// Optional macro STREAM_TESTER_ERR_INJECT_EN adds inject_err (bit0 flip on next TX word).
module stream_pattern_tester #(
    parameter int TX_DW    = 64,
    parameter int RX_DW    = 8,
    parameter int CNT_W    = 32,
    parameter int LED_HOLD = 50000000,
    parameter int RESYNC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
`ifdef STREAM_TESTER_ERR_INJECT_EN
    input  logic             inject_err,
`endif
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [TX_DW-1:0] tx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [RX_DW-1:0] rx_data,
    output logic             locked,
    output logic             err_led,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt
);

    localparam int HW = ($clog2(LED_HOLD + 1) > 0) ? $clog2(LED_HOLD + 1) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_RUN, TX_DRAIN} tx_st_e;
    typedef enum logic [1:0] {RX_IDLE, RX_HUNT, RX_LOCK} rx_st_e;

    function automatic logic [TX_DW-1:0] tx_seed(input logic [1:0] m);
        case (m)
            2'd2:    tx_seed = TX_DW'(1);
            2'd3:    tx_seed = {(TX_DW/8){8'hA5}};
            default: tx_seed = '0;
        endcase
    endfunction

    function automatic logic [TX_DW-1:0] tx_next(input logic [1:0] m,
                                                 input logic [TX_DW-1:0] x);
        case (m)
            2'd0:    tx_next = x + TX_DW'(1);
            2'd1:    tx_next = x - TX_DW'(1);
            2'd2:    tx_next = (x == '0) ? TX_DW'(1)
                                         : {x[TX_DW-2:0], x[TX_DW-1]};
            default: tx_next = {(TX_DW/8){8'hA5}};
        endcase
    endfunction

    function automatic logic [RX_DW-1:0] rx_next(input logic [1:0] m,
                                                 input logic [RX_DW-1:0] x);
        case (m)
            2'd0:    rx_next = x + RX_DW'(1);
            2'd1:    rx_next = x - RX_DW'(1);
            2'd2:    rx_next = (x == '0) ? RX_DW'(1)
                                         : {x[RX_DW-2:0], x[RX_DW-1]};
            default: rx_next = {(RX_DW/8){8'hA5}};
        endcase
    endfunction

    // ---------------- TX side ----------------
    tx_st_e             tx_st_q, tx_st_d;
    logic [1:0]         tx_mode_q, tx_mode_d;
    logic [TX_DW-1:0]   tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic               tx_hs;
    logic               inj_q, inj_d;

    assign tx_valid = (tx_st_q != TX_IDLE);
    assign tx_hs    = tx_valid & tx_ready;
    assign tx_cnt   = tx_cnt_q;
    assign tx_data  = tx_data_q ^ TX_DW'(inj_q);

    // TX next-state: sequence advances on handshake, valid never drops without one
    always_comb begin
        tx_st_d   = tx_st_q;
        tx_mode_d = tx_mode_q;
        tx_data_d = tx_data_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_hs) begin
            tx_data_d = tx_next(tx_mode_q, tx_data_q);
            tx_cnt_d  = tx_cnt_q + CNT_W'(1);
        end
        case (tx_st_q)
            TX_IDLE: begin
                if (enable) begin
                    tx_st_d   = TX_RUN;
                    tx_mode_d = mode;
                    tx_data_d = tx_seed(mode);
                    tx_cnt_d  = '0;
                end
            end
            TX_RUN: begin
                if (!enable) tx_st_d = tx_hs ? TX_IDLE : TX_DRAIN;
            end
            TX_DRAIN: begin
                if (tx_hs) tx_st_d = TX_IDLE;
            end
            default: tx_st_d = TX_IDLE;
        endcase
    end

    // Injection flag: armed by a pulse, consumed by the next handshake
    always_comb begin
        inj_d = inj_q;
`ifdef STREAM_TESTER_ERR_INJECT_EN
        if (tx_hs && inj_q) inj_d = 1'b0;
        else if (inject_err) inj_d = 1'b1;
`endif
    end

    // TX state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q   <= TX_IDLE;
            tx_mode_q <= 2'd0;
            tx_data_q <= '0;
            tx_cnt_q  <= '0;
            inj_q     <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_mode_q <= tx_mode_d;
            tx_data_q <= tx_data_d;
            tx_cnt_q  <= tx_cnt_d;
            inj_q     <= inj_d;
        end
    end

    // ---------------- RX side ----------------
    rx_st_e             rx_st_q, rx_st_d;
    logic [1:0]         rx_mode_q, rx_mode_d;
    logic [RX_DW-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]         miss_q, miss_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               rx_ready_q, locked_q, err_led_q;
    logic               rx_acc;

    assign rx_ready = rx_ready_q;
    assign rx_acc   = rx_valid & rx_ready_q;
    assign locked   = locked_q;
    assign err_led  = err_led_q;
    assign err_cnt  = err_cnt_q;
    assign rx_cnt   = rx_cnt_q;

    // RX next-state: lock on first word, check, reseed from every received word
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_mode_d = rx_mode_q;
        exp_d     = exp_q;
        err_cnt_d = err_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        miss_d    = miss_q;
        hold_d    = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
        case (rx_st_q)
            RX_IDLE: begin
                if (enable) begin
                    rx_st_d   = RX_HUNT;
                    rx_mode_d = mode;
                    err_cnt_d = '0;
                    rx_cnt_d  = '0;
                    miss_d    = '0;
                end
            end
            RX_HUNT: begin
                if (rx_acc) begin
                    rx_st_d  = RX_LOCK;
                    exp_d    = rx_next(rx_mode_q, rx_data);
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_LOCK: begin
                if (rx_acc) begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    exp_d    = rx_next(rx_mode_q, rx_data);
                    if (rx_data == exp_q) begin
                        miss_d = '0;
                    end else begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                        hold_d = HW'(LED_HOLD);
                        if (miss_q + 8'd1 == 8'(RESYNC)) begin
                            rx_st_d = RX_HUNT;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 8'd1;
                        end
                    end
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
        if (rx_st_q != RX_IDLE && !enable) rx_st_d = RX_IDLE;
    end

    // RX state registers; ready rises on the first cycle out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st_q    <= RX_IDLE;
            rx_mode_q  <= 2'd0;
            exp_q      <= '0;
            err_cnt_q  <= '0;
            rx_cnt_q   <= '0;
            miss_q     <= '0;
            hold_q     <= '0;
            rx_ready_q <= 1'b0;
            locked_q   <= 1'b0;
            err_led_q  <= 1'b0;
        end else begin
            rx_st_q    <= rx_st_d;
            rx_mode_q  <= rx_mode_d;
            exp_q      <= exp_d;
            err_cnt_q  <= err_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            miss_q     <= miss_d;
            hold_q     <= hold_d;
            rx_ready_q <= 1'b1;
            locked_q   <= (rx_st_d == RX_LOCK);
            err_led_q  <= (hold_d != '0);
        end
    end

endmodule

// File: tb/tb_stream_pattern_tester.sv
// Directed bench for stream_pattern_tester: RX vector table plus
// hand-written loopback, LED hold, drain, 64-bit decrement sequences.
module tb_stream_pattern_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, loop, inj;
    logic [1:0] mode;
    logic       tx_ready_d, rx_valid_d;
    logic [7:0] rx_data_d;

    logic       tx_valid, tx_ready_w, rx_valid_w, rx_ready;
    logic [7:0] tx_data, rx_data_w;
    logic       locked, err_led;
    logic [31:0] err_cnt, tx_cnt, rx_cnt;

    assign tx_ready_w = loop ? 1'b1 : tx_ready_d;
    assign rx_valid_w = loop ? tx_valid : rx_valid_d;
    assign rx_data_w  = loop ? tx_data : rx_data_d;

    stream_pattern_tester #(
        .TX_DW(8), .RX_DW(8), .CNT_W(32), .LED_HOLD(20), .RESYNC(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
`ifdef STREAM_TESTER_ERR_INJECT_EN
        .inject_err(inj),
`endif
        .tx_valid(tx_valid), .tx_ready(tx_ready_w), .tx_data(tx_data),
        .rx_valid(rx_valid_w), .rx_ready(rx_ready), .rx_data(rx_data_w),
        .locked(locked), .err_led(err_led), .err_cnt(err_cnt),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
    );

    logic        en64, tr64;
    logic [1:0]  mode64;
    logic        v64, rr64, lk64, led64;
    logic [63:0] d64;
    logic [31:0] ec64, tc64, rc64;

    stream_pattern_tester #(
        .TX_DW(64), .RX_DW(8), .CNT_W(32), .LED_HOLD(20), .RESYNC(4)
    ) dut64 (
        .clk(clk), .rst(rst), .enable(en64), .mode(mode64),
`ifdef STREAM_TESTER_ERR_INJECT_EN
        .inject_err(1'b0),
`endif
        .tx_valid(v64), .tx_ready(tr64), .tx_data(d64),
        .rx_valid(1'b0), .rx_ready(rr64), .rx_data(8'h00),
        .locked(lk64), .err_led(led64), .err_cnt(ec64),
        .tx_cnt(tc64), .rx_cnt(rc64)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; enable = 1'b0; en64 = 1'b0; loop = 1'b0; inj = 1'b0;
        rx_valid_d = 1'b0; rx_data_d = 8'h00; tx_ready_d = 1'b0;
        tr64 = 1'b0; mode = 2'd0; mode64 = 2'd0;
        tick; tick;
        rst = 1'b0;
    endtask

    typedef struct {
        bit         start;
        logic [1:0] mode;
        logic [7:0] d;
        int         e_err;
        bit         e_lock;
        int         e_cnt;
    } vec_t;

    vec_t tbl[12];
    int   led_n;

    initial begin
        tbl[0]  = '{1, 2'd0, 8'h10, 0, 1, 1};
        tbl[1]  = '{0, 2'd0, 8'h11, 0, 1, 2};
        tbl[2]  = '{0, 2'd0, 8'h13, 1, 1, 3};
        tbl[3]  = '{0, 2'd0, 8'h14, 1, 1, 4};
        tbl[4]  = '{1, 2'd2, 8'h01, 0, 1, 1};
        tbl[5]  = '{0, 2'd2, 8'h02, 0, 1, 2};
        tbl[6]  = '{0, 2'd2, 8'h00, 1, 1, 3};
        tbl[7]  = '{0, 2'd2, 8'h00, 2, 1, 4};
        tbl[8]  = '{0, 2'd2, 8'h00, 3, 1, 5};
        tbl[9]  = '{0, 2'd2, 8'h00, 4, 0, 6};
        tbl[10] = '{0, 2'd2, 8'h08, 4, 1, 7};
        tbl[11] = '{0, 2'd2, 8'h10, 4, 1, 8};

        // reset values
        do_reset;
        rst = 1'b1;
        tick;
        chk("rst tx_valid", 64'(tx_valid), 64'd0);
        chk("rst rx_ready", 64'(rx_ready), 64'd0);
        chk("rst locked",   64'(locked),   64'd0);
        chk("rst err_led",  64'(err_led),  64'd0);
        chk("rst tx_data",  64'(tx_data),  64'd0);
        chk("rst cnts",     64'(err_cnt | tx_cnt | rx_cnt), 64'd0);
        rst = 1'b0;
        tick;
        chk("rx_ready up", 64'(rx_ready), 64'd1);

        // table-driven RX checks
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].start) begin
                do_reset;
                enable = 1'b1;
                mode   = tbl[i].mode;
                tick;
            end
            rx_valid_d = 1'b1;
            rx_data_d  = tbl[i].d;
            tick;
            rx_valid_d = 1'b0;
            chk($sformatf("v%0d err_cnt", i), 64'(err_cnt), 64'(tbl[i].e_err));
            chk($sformatf("v%0d locked", i),  64'(locked),  64'(tbl[i].e_lock));
            chk($sformatf("v%0d rx_cnt", i),  64'(rx_cnt),  64'(tbl[i].e_cnt));
        end

        // loopback 300 words, increment
        do_reset;
        loop = 1'b1; mode = 2'd0; enable = 1'b1;
        tick;
        for (int k = 0; k < 299; k++) begin
            tick;
            if (k == 1) chk("loop locked", 64'(locked), 64'd1);
            if (k == 254) chk("loop ff", 64'(tx_data), 64'hFF);
            if (k == 255) chk("loop wrap", 64'(tx_data), 64'h00);
        end
        chk("loop locked end", 64'(locked), 64'd1);
        enable = 1'b0;
        tick;
        chk("loop tx_cnt",  64'(tx_cnt),  64'd300);
        chk("loop rx_cnt",  64'(rx_cnt),  64'd300);
        chk("loop err_cnt", 64'(err_cnt), 64'd0);
        chk("loop tx idle", 64'(tx_valid), 64'd0);

        // LED hold length after a single mismatch
        do_reset;
        enable = 1'b1; mode = 2'd0;
        tick;
        rx_valid_d = 1'b1;
        rx_data_d = 8'h10; tick;
        rx_data_d = 8'h11; tick;
        rx_data_d = 8'h13; tick;
        rx_valid_d = 1'b0;
        led_n = 0;
        for (int k = 0; k < 100; k++) begin
            if (!err_led) break;
            led_n++;
            tick;
        end
        chk("led hold cycles", 64'(led_n),  64'd20);
        chk("led err_cnt",     64'(err_cnt), 64'd1);
        chk("led locked",      64'(locked),  64'd1);

        // drain: valid held until a handshake
        do_reset;
        enable = 1'b1; mode = 2'd0; tx_ready_d = 1'b0;
        tick;
        chk("run valid", 64'(tx_valid), 64'd1);
        enable = 1'b0;
        tick; tick;
        chk("drain valid", 64'(tx_valid), 64'd1);
        chk("drain data",  64'(tx_data),  64'd0);
        tx_ready_d = 1'b1;
        tick;
        tx_ready_d = 1'b0;
        chk("drain done valid", 64'(tx_valid), 64'd0);
        chk("drain tx_cnt",     64'(tx_cnt),   64'd1);
        tick;
        chk("idle valid", 64'(tx_valid), 64'd0);

        // 64-bit decrement, mode change mid-run ignored
        do_reset;
        en64 = 1'b1; mode64 = 2'd1;
        tick;
        chk("dec64 w0", d64, 64'd0);
        mode64 = 2'd2; tr64 = 1'b1;
        tick;
        chk("dec64 w1", d64, 64'hFFFF_FFFF_FFFF_FFFF);
        tick;
        chk("dec64 w2", d64, 64'hFFFF_FFFF_FFFF_FFFE);
        tr64 = 1'b0;
        tick;
        chk("dec64 hold", d64, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("dec64 cnt",  64'(tc64), 64'd2);

`ifdef STREAM_TESTER_ERR_INJECT_EN
        do_reset;
        loop = 1'b1; mode = 2'd0; enable = 1'b1;
        tick;
        tick; tick; tick; tick;
        inj = 1'b1;
        tick;
        inj = 1'b0;
        chk("inj word5", 64'(tx_data), 64'h04);
        tick; tick; tick;
        chk("inj err_cnt", 64'(err_cnt), 64'd2);
        chk("inj locked",  64'(locked),  64'd1);
        chk("inj resume",  64'(tx_data), 64'h08);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
